mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the cache's line fill and writeback traffic.
- Accepts one block request at a time and waits a fixed access latency.
- Then streams one 32-bit word per cycle: a fill burst (memory to cache) or a writeback burst (cache to memory).
- Presents the current word address on mem_addr_o, which feeds the cache set's memory address input; read_data_o feeds its memory read data input.

Parameters:
OFFSET_WIDTH, `CACHE_B, log2 of block size in bytes; beats per burst BEATS = 2^(OFFSET_WIDTH-2).
MEM_WORDS, 1024, backing array depth in 32-bit words (power of two).
LATENCY, 4, idle cycles between request accept and first beat (0 allowed).

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request present
req_write_i  input  1  1 = writeback burst, 0 = fill burst
req_addr_i  input  32  any byte address inside the target block
req_ready_o  output  1  high only in IDLE; request accepted when req_valid_i & req_ready_o
write_data_i  input  32  writeback word for the current beat
write_ready_o  output  1  high on each writeback beat; write_data_i stored that cycle
read_data_o  output  32  fill word for the current beat
read_valid_o  output  1  high on each fill beat
mem_addr_o  output  32  byte address of the current beat (block base + 4*beat)
done_o  output  1  one-cycle pulse after the last beat

Behaviour:
- States: IDLE, WAIT, READ_BURST, WRITE_BURST, DONE.
- Reset:
  - state goes to IDLE.
  - Beat and latency counters go to 0.
  - read_valid_o, write_ready_o and done_o are 0; mem_addr_o and read_data_o are 0.
  - req_ready_o is 0 during the reset cycle and 1 from the first cycle after it.
  - Array contents are not cleared by reset and are zero at time 0 in simulation.
- IDLE, on accept:
  - Latch base = req_addr_i with bits [OFFSET_WIDTH-1:0] cleared; latch the write flag.
  - If LATENCY > 0: go to WAIT and load the counter with LATENCY-1.
  - If LATENCY = 0: go directly to READ_BURST or WRITE_BURST.
- WAIT: decrement each cycle. At 0, go to the burst state given by the latched flag. Accept-to-first-beat is exactly LATENCY+1 cycles.
- Outputs during WAIT and DONE: mem_addr_o = base; read_data_o = 0; read_valid_o, write_ready_o and req_ready_o are all 0.
- READ_BURST, beat k = 0..BEATS-1, one per cycle with no stalls:
  - read_valid_o = 1.
  - mem_addr_o = base + 4k.
  - read_data_o = array[word index of mem_addr_o], an asynchronous read.
- WRITE_BURST, beat k:
  - write_ready_o = 1 and mem_addr_o = base + 4k.
  - array[index] <= write_data_i at the clock edge ending the beat.
  - The requester must hold valid data on every beat; there is no backpressure.
- After beat BEATS-1, go to DONE: done_o = 1 for one cycle, then IDLE. A new request is accepted one cycle after done_o at the earliest.
- Word index = addr[$clog2(MEM_WORDS)+1:2]. Higher address bits are ignored, so aliasing and wrap-around are intended.
- Beat addresses never cross a block boundary. Low offset bits of req_addr_i never affect beat order, which always starts at beat 0.
- req_valid_i while not in IDLE: ignored, with no queueing. req_write_i, req_addr_i and write_data_i are don't-care outside their accept/beat cycles.
- Reset mid-operation: abort and enter IDLE with reset output values. Beats already written stay in the array. No done_o is issued for the aborted burst.
- Beat counter width is OFFSET_WIDTH-2 bits (minimum 1). The last-beat compare is against BEATS-1.

Decomposition:
- cache.svh gains `MEM_WORDS and `MEM_LATENCY defaults beside `CACHE_B.
- The state enum is a local typedef in this module, since no other block uses it.
- One sub-module, mem_array: MEM_WORDS x 32, one synchronous write port and one asynchronous read port, no reset.
- The FSM, counters and address generation stay in mem_responder.

Test Plan (OFFSET_WIDTH=4, BEATS=4, LATENCY=3, MEM_WORDS=1024):
1. Fill: preload words 0x40..0x4C = A0,A1,A2,A3; request read at 0x48.
   -> req_ready_o drops the next cycle; 3 WAIT cycles follow.
   -> 4 beats with mem_addr_o 0x40,0x44,0x48,0x4C and read_data_o A0..A3.
   -> done_o pulses 1 cycle, then req_ready_o = 1.
2. Writeback: request write at 0x80 and drive 0x11,0x22,0x33,0x44 on the beats; then fill 0x80.
   -> Fill returns 0x11,0x22,0x33,0x44.
3. Busy / back-to-back: hold req_valid_i high throughout.
   -> Second accept occurs exactly one cycle after done_o.
   -> A request toggled during WAIT and during the burst is never accepted.
4. Reset on beat 2 of a writeback to 0xC0 with data 1,2,3,4.
   -> Next cycle all outputs hold reset values.
   -> A fill of 0xC0 returns 1,2,old,old; no done_o for the aborted burst.
5. LATENCY=0: fill request -> first beat on the cycle immediately after accept; 6 cycles from accept to done_o inclusive.
6. Aliasing: write a block at 0x1000, then fill 0x0000 -> identical data is returned.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: default geometry and counter sizing shared by the memory responder files
package mem_responder_pkg;
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_MEM_WORDS = 1024;
  localparam int DEF_MEM_LATENCY = 4;
  function automatic int beat_width(input int offset_width);
    return offset_width > 3 ? offset_width - 2 : 1;
  endfunction
  function automatic int lat_width(input int latency);
    return latency > 1 ? $clog2(latency) : 1;
  endfunction
endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: word-wide backing store, one synchronous write port and one asynchronous read port
module mem_array #(
  parameter int WORDS = 1024,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency block responder streaming fill and writeback bursts one word per cycle
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int LATENCY = DEF_MEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  input  logic [31:0] write_data_i,
  output logic        write_ready_o,
  output logic [31:0] read_data_o,
  output logic        read_valid_o,
  output logic [31:0] mem_addr_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, WAIT, READ_BURST, WRITE_BURST, DONE} state_t;
  localparam int BEATS = 1 << (OFFSET_WIDTH - 2);
  localparam int BW = beat_width(OFFSET_WIDTH);
  localparam int LW = lat_width(LATENCY);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY > 0 ? LATENCY - 1 : 0);
  state_t state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [LW-1:0] lat, lat_n;
  logic [31:0] base, base_n, beat_addr, rdata;
  logic wr, wr_n, unused_bits;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      beat <= '0;
      lat <= '0;
      base <= '0;
      wr <= 1'b0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      lat <= lat_n;
      base <= base_n;
      wr <= wr_n;
    end
  always_comb begin
    state_n = state;
    beat_n = beat;
    lat_n = lat;
    base_n = base;
    wr_n = wr;
    case (state)
      IDLE: if (req_valid_i) begin
        base_n = {req_addr_i[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        wr_n = req_write_i;
        beat_n = '0;
        lat_n = LAT_LOAD;
        state_n = LATENCY > 0 ? WAIT : (req_write_i ? WRITE_BURST : READ_BURST);
      end
      WAIT: begin
        lat_n = lat - LW'(1);
        if (lat == '0) state_n = wr ? WRITE_BURST : READ_BURST;
      end
      READ_BURST, WRITE_BURST: begin
        beat_n = beat + BW'(1);
        if (beat == LAST) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are forced to their reset values while rst_i is high so an aborted beat never writes.
  assign beat_addr = base + {{(30 - BW){1'b0}}, beat, 2'b00};
  assign req_ready_o = ~rst_i & (state == IDLE);
  assign read_valid_o = ~rst_i & (state == READ_BURST);
  assign write_ready_o = ~rst_i & (state == WRITE_BURST);
  assign done_o = ~rst_i & (state == DONE);
  assign read_data_o = read_valid_o ? rdata : '0;
  assign mem_addr_o = (rst_i || state == IDLE) ? '0 : (read_valid_o | write_ready_o) ? beat_addr : base;
  assign unused_bits = ^{req_addr_i[OFFSET_WIDTH-1:0], beat_addr[31:AW+2], beat_addr[1:0]};
  mem_array #(.WORDS(MEM_WORDS)) u_array (
    .clk_i(clk_i),
    .we(write_ready_o),
    .waddr(beat_addr[AW+1:2]),
    .wdata(write_data_i),
    .raddr(beat_addr[AW+1:2]),
    .rdata(rdata)
  );
endmodule
